// File: rtl/bomb_control.sv
// Bomb placement/fuse/explosion controller for a Bomberman-style VGA game.
// Latches the tile under the player's hitbox, times fuse and explosion, and draws both.
module bomb_control #(
  parameter int FUSE_TICKS = 150000000,
  parameter int EXP_TICKS  = 37500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place,
  input  logic       gameover,
  input  logic [9:0] x_b,
  input  logic [9:0] y_b,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       bomb_active,
  output logic       exp_active,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic       bomb_on,
  output logic       exp_on,
  output logic       bomb_done,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FUSE    = 2'd1;
  localparam logic [1:0] S_EXPLODE = 2'd2;

  localparam logic [27:0] FUSE_LAST = 28'(FUSE_TICKS - 1);
  localparam logic [27:0] EXP_LAST  = 28'(EXP_TICKS - 1);

  logic [1:0]  state;
  logic [27:0] counter;
  logic        place_q;
  logic        place_edge;
  logic [9:0]  col_px;
  logic [9:0]  row_px;
  logic [9:0]  tile_x;
  logic [9:0]  tile_y;

  assign place_edge = place & ~place_q;

  // Hitbox centre snapped to the 16-pixel grid of the arena (origin 48,32).
  assign col_px = x_b + 10'd8 - 10'd48;
  assign row_px = y_b + 10'd17 - 10'd32;
  assign tile_x = 10'd48 + (col_px & 10'h3F0);
  assign tile_y = 10'd32 + (row_px & 10'h3F0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      place_q   <= 1'b0;
      bomb_x    <= 10'd48;
      bomb_y    <= 10'd32;
      bomb_done <= 1'b0;
    end else begin
      place_q   <= place;
      bomb_done <= 1'b0;
      case (state)
        S_FUSE: begin
          if (gameover) begin
            state   <= S_IDLE;
            counter <= '0;
          end else if (counter == FUSE_LAST) begin
            state   <= S_EXPLODE;
            counter <= '0;
          end else begin
            counter <= counter + 28'd1;
          end
        end
        S_EXPLODE: begin
          if (gameover) begin
            state   <= S_IDLE;
            counter <= '0;
          end else if (counter == EXP_LAST) begin
            state     <= S_IDLE;
            counter   <= '0;
            bomb_done <= 1'b1;
          end else begin
            counter <= counter + 28'd1;
          end
        end
        default: begin
          counter <= '0;
          if (place_edge && !gameover) begin
            state  <= S_FUSE;
            bomb_x <= tile_x;
            bomb_y <= tile_y;
          end
        end
      endcase
    end
  end

  assign bomb_active = (state == S_FUSE);
  assign exp_active  = (state == S_EXPLODE);
  assign dbg_state   = state;

  // 11-bit compares keep the cross arms from wrapping past pixel 0 or 1023.
  logic [10:0] px, py, bx, by;
  logic        in_tile_x, in_tile_y, in_arm_x, in_arm_y, in_arena;

  assign px = {1'b0, x};
  assign py = {1'b0, y};
  assign bx = {1'b0, bomb_x};
  assign by = {1'b0, bomb_y};

  assign in_tile_x = (px >= bx) && (px <= bx + 11'd15);
  assign in_tile_y = (py >= by) && (py <= by + 11'd15);
  assign in_arm_x  = (px + 11'd16 >= bx) && (px <= bx + 11'd31);
  assign in_arm_y  = (py + 11'd16 >= by) && (py <= by + 11'd31);
  assign in_arena  = (x >= 10'd48) && (x <= 10'd575) && (y >= 10'd32) && (y <= 10'd447);

  assign bomb_on = bomb_active & in_tile_x & in_tile_y;
  assign exp_on  = exp_active & in_arena &
                   ((in_arm_x & in_tile_y) | (in_tile_x & in_arm_y));

endmodule

// File: tb/tb_bomb_control.sv
// Self-checking bench for bomb_control: countdown model checked every cycle
// plus directed literal checks of tile latching, timing, cross clipping and aborts.
module tb_bomb_control;

  localparam int FUSE = 10;
  localparam int EXPL = 4;
  localparam int W    = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       place;
  logic       gameover;
  logic [9:0] x_b, y_b, x, y;
  logic       bomb_active, exp_active, bomb_on, exp_on, bomb_done;
  logic [9:0] bomb_x, bomb_y;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic sweep = 1'b0;
  logic [W-1:0] exp_q[$];

  bomb_control #(.FUSE_TICKS(FUSE), .EXP_TICKS(EXPL)) dut (
    .clk(clk), .reset(reset), .place(place), .gameover(gameover),
    .x_b(x_b), .y_b(y_b), .x(x), .y(y),
    .bomb_active(bomb_active), .exp_active(exp_active),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_on(bomb_on), .exp_on(exp_on),
    .bomb_done(bomb_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int m_fuse_left, m_exp_left, m_bx, m_by;
  logic m_place_q, m_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fuse_left = 0; m_exp_left = 0; m_place_q = 0; m_done = 0;
      m_bx = 48; m_by = 32;
    end else begin
      logic pe;
      pe = place & ~m_place_q;
      m_place_q = place;
      m_done = 0;
      if (m_fuse_left > 0) begin
        if (gameover) m_fuse_left = 0;
        else begin
          m_fuse_left--;
          if (m_fuse_left == 0) m_exp_left = EXPL;
        end
      end else if (m_exp_left > 0) begin
        if (gameover) m_exp_left = 0;
        else begin
          m_exp_left--;
          if (m_exp_left == 0) m_done = 1;
        end
      end else if (pe && !gameover) begin
        m_fuse_left = FUSE;
        m_bx = (48 + (((int'(x_b) + 8 - 48) & 1023) / 16) * 16) & 1023;
        m_by = (32 + (((int'(y_b) + 17 - 32) & 1023) / 16) * 16) & 1023;
      end
    end
  end

  function automatic logic [W-1:0] model_vec();
    int xi, yi;
    logic e_bomb, e_exp, on_b, on_e, arena, h_arm, v_arm;
    xi = int'(x); yi = int'(y);
    e_bomb = (m_fuse_left > 0);
    e_exp  = (m_exp_left > 0);
    on_b = e_bomb && xi >= m_bx && xi <= m_bx + 15 && yi >= m_by && yi <= m_by + 15;
    arena = xi >= 48 && xi <= 575 && yi >= 32 && yi <= 447;
    h_arm = xi >= m_bx - 16 && xi <= m_bx + 31 && yi >= m_by && yi <= m_by + 15;
    v_arm = xi >= m_bx && xi <= m_bx + 15 && yi >= m_by - 16 && yi <= m_by + 31;
    on_e = e_exp && arena && (h_arm || v_arm);
    return {e_bomb, e_exp, on_b, on_e, m_done, 10'(m_bx), 10'(m_by)};
  endfunction

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, expv;
    exp_q.push_back(model_vec());
    act = {bomb_active, exp_active, bomb_on, exp_on, bomb_done, bomb_x, bomb_y};
    expv = exp_q.pop_front();
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL cycle_vec t=%0t: got %h expected %h", $time, act, expv);
    end
  end

  // Pixel sweep around the bomb so bomb_on/exp_on get exercised by the scoreboard.
  always @(posedge clk) begin
    if (sweep) begin
      #1;
      x = 10'(m_bx - 24 + int'($urandom_range(0, 72)));
      y = 10'(m_by - 24 + int'($urandom_range(0, 72)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    place = 1'b1;
    tick();
    place = 1'b0;
  endtask

  // which: 0 = bomb_active, 1 = exp_active, 2 = idle
  task automatic wait_flag(input string name, input int which, input int max_cyc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = bomb_active;
        1: hit = exp_active;
        default: hit = !bomb_active && !exp_active;
      endcase
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic count_seq(output int f_n, output int e_n, output int d_n, output int bx0);
    f_n = 0; e_n = 0; d_n = 0; bx0 = -1;
    repeat (30) begin
      @(negedge clk);
      if (bomb_active) begin
        f_n++;
        if (bx0 < 0) bx0 = int'(bomb_x);
      end
      if (exp_active) e_n++;
      if (bomb_done) d_n++;
    end
  endtask

  task automatic probe(input string name, input int px, input int py, input int expv);
    x = 10'(px); y = 10'(py);
    #1;
    chk(name, int'(exp_on), expv);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int f_n, e_n, d_n, bx0, arms;
    logic prev;
    int xb_list[2];
    int exp_bx[2];
    xb_list[0] = 551; exp_bx[0] = 544;
    xb_list[1] = 567; exp_bx[1] = 560;

    reset = 1'b0; place = 1'b0; gameover = 1'b0;
    x_b = 10'd64; y_b = 10'd23; x = '0; y = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_bomb_x", int'(bomb_x), 48);
    chk("rst_bomb_y", int'(bomb_y), 32);
    chk("rst_flags", int'({bomb_active, exp_active, bomb_on, exp_on, bomb_done}), 0);
    chk("rst_state", int'(dbg_state), 0);
    tick();
    reset = 1'b1;
    tick();

    // Basic fuse/explode/done sequence.
    sweep = 1'b1;
    arm();
    count_seq(f_n, e_n, d_n, bx0);
    chk("basic_fuse_len", f_n, 10);
    chk("basic_exp_len", e_n, 4);
    chk("basic_done_len", d_n, 1);
    chk("basic_bomb_x", bx0, 64);
    chk("basic_bomb_y", int'(bomb_y), 32);

    // Held button arms only once.
    tick();
    place = 1'b1;
    arms = 0; prev = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bomb_active && !prev) arms++;
      prev = bomb_active;
    end
    chk("held_arms", arms, 1);
    tick();
    place = 1'b0;
    tick();
    arm();
    @(negedge clk);
    chk("rearm_after_release", int'(bomb_active), 1);
    wait_flag("rearm_idle", 2, 30);
    sweep = 1'b0;

    // Right/bottom arena edge.
    for (int i = 0; i < 2; i++) begin
      tick();
      x_b = 10'(xb_list[i]); y_b = 10'd415;
      arm();
      wait_flag("edge_exp", 1, 20);
      chk("edge_bomb_x", int'(bomb_x), exp_bx[i]);
      chk("edge_bomb_y", int'(bomb_y), 432);
      probe("edge_in_544_440", 544, 440, 1);
      probe("edge_out_576_440", 576, 440, 0);
      probe("edge_out_565_448", 565, 448, 0);
      wait_flag("edge_idle", 2, 20);
    end

    // Top-left arena corner: arms must not wrap.
    tick();
    x_b = 10'd40; y_b = 10'd20;
    arm();
    wait_flag("corner_exp", 1, 20);
    chk("corner_bomb_x", int'(bomb_x), 48);
    chk("corner_bomb_y", int'(bomb_y), 32);
    probe("corner_in_64_40", 64, 40, 1);
    probe("corner_in_56_48", 56, 48, 1);
    probe("corner_out_32_40", 32, 40, 0);
    probe("corner_out_1023_40", 1023, 40, 0);
    probe("corner_out_56_16", 56, 16, 0);
    wait_flag("corner_idle", 2, 20);

    // Gameover aborts the fuse and blocks new bombs.
    tick();
    x_b = 10'd64; y_b = 10'd23;
    arm();
    repeat (4) tick();
    gameover = 1'b1;
    tick();
    @(negedge clk);
    chk("go_abort_active", int'(bomb_active), 0);
    chk("go_abort_done", int'(bomb_done), 0);
    chk("go_hold_bomb_x", int'(bomb_x), 64);
    tick();
    arm();
    @(negedge clk);
    chk("go_blocks_place", int'(bomb_active), 0);
    tick();
    gameover = 1'b0;
    tick();

    // Reset mid-explosion, then place held across release arms immediately.
    sweep = 1'b1;
    arm();
    wait_flag("rst_exp", 1, 20);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_flags", int'({bomb_active, exp_active, bomb_on, exp_on, bomb_done}), 0);
    place = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    place = 1'b0;
    count_seq(f_n, e_n, d_n, bx0);
    chk("post_rst_fuse_len", f_n, 10);
    chk("post_rst_exp_len", e_n, 4);
    chk("post_rst_done_len", d_n, 1);
    sweep = 1'b0;

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
